region_blitter: RTL and testbench

REGION_BLITTER -- requirements
Module: region_blitter

---
 rtl/region_blitter_if.sv | 42 ++++
 rtl/region_blitter.sv | 171 +++++++++++++++++
 tb/tb_region_blitter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/region_blitter_if.sv
// Command, ROM and pixel-write signals shared between a region blitter and its
// surrounding frame-buffer logic.
interface region_blitter_if #(
  parameter int XW   = 9,
  parameter int YW   = 8,
  parameter int COLW = 3,
  parameter int AW   = 17,
  parameter int SELW = 4
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [XW-1:0]   cmd_x0;
  logic [YW-1:0]   cmd_y0;
  logic [XW-1:0]   cmd_w;
  logic [YW-1:0]   cmd_h;
  logic [AW-1:0]   cmd_base;
  logic [SELW-1:0] cmd_sel;
  logic            cmd_key_en;
  logic [COLW-1:0] cmd_key;
  logic            abort;
  logic [AW-1:0]   rom_addr;
  logic [SELW-1:0] rom_sel;
  logic [COLW-1:0] rom_data;
  logic            write_en;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [COLW-1:0] colour;
  logic            busy;
  logic            done;

  modport slave (
    input  cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_base, cmd_sel,
           cmd_key_en, cmd_key, abort, rom_data,
    output cmd_ready, rom_addr, rom_sel, write_en, x, y, colour, busy, done
  );

  modport master (
    output cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_base, cmd_sel,
           cmd_key_en, cmd_key, abort, rom_data,
    input  cmd_ready, rom_addr, rom_sel, write_en, x, y, colour, busy, done
  );
endinterface

// File: rtl/region_blitter.sv
// Copies a rectangular region from a synchronous image ROM to the screen, one
// pixel per cycle, with screen clipping and optional colour-key transparency.
module region_blitter #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int XW       = 9,
  parameter int YW       = 8,
  parameter int COLW     = 3,
  parameter int AW       = 17,
  parameter int SELW     = 4
) (
  input  logic          clock,
  input  logic          resetn,
  region_blitter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam logic [XW:0] X_LIMIT = (XW+1)'(SCREEN_W);
  localparam logic [YW:0] Y_LIMIT = (YW+1)'(SCREEN_H);

  function automatic logic x_clipped(input logic [XW:0] xs);
    return xs >= X_LIMIT;
  endfunction

  function automatic logic y_clipped(input logic [YW:0] ys);
    return ys >= Y_LIMIT;
  endfunction

  function automatic logic keyed_out(input logic en, input logic [COLW-1:0] key,
                                     input logic [COLW-1:0] pix);
    return en && (pix == key);
  endfunction

  state_t          state_q, state_d;
  logic            flush_q, flush_d;
  logic            accept, kill, last_pix, zero_size, vld_p0;

  logic [XW-1:0]   x0_q, w_q, col_p0;
  logic [YW-1:0]   y0_q, h_q, row_p0;
  logic            key_en_q;
  logic [COLW-1:0] key_q;
  logic [AW-1:0]   rom_addr_p0;
  logic [SELW-1:0] rom_sel_q;

  logic            vld_p1;
  logic [XW:0]     x_p1;
  logic [YW:0]     y_p1;

  logic            vld_p2;
  logic [XW-1:0]   x_p2;
  logic [YW-1:0]   y_p2;
  logic [COLW-1:0] colour_p2;

  assign accept    = bus.cmd_valid && (state_q == IDLE);
  assign zero_size = (bus.cmd_w == '0) || (bus.cmd_h == '0);
  assign kill      = bus.abort && ((state_q == RUN) || (state_q == FLUSH));
  assign last_pix  = (col_p0 == w_q - XW'(1)) && (row_p0 == h_q - YW'(1));
  assign vld_p0    = (state_q == RUN);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = zero_size ? DONE : RUN;
      end
      RUN: begin
        if (kill) begin
          state_d = IDLE;
        end else if (last_pix) begin
          state_d = FLUSH;
          flush_d = 1'b0;
        end
      end
      FLUSH: begin
        if (kill)         state_d = IDLE;
        else if (flush_q) state_d = DONE;
        else              flush_d = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: raster scan. The ROM address is base plus the linear pixel index,
  // so a plain increment tracks row*w+col without any multiply.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      rom_addr_p0 <= '0;
      rom_sel_q   <= '0;
    end else if (accept) begin
      rom_addr_p0 <= bus.cmd_base;
      rom_sel_q   <= bus.cmd_sel;
    end else if (vld_p0 && !kill) begin
      rom_addr_p0 <= rom_addr_p0 + AW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      x0_q     <= bus.cmd_x0;
      y0_q     <= bus.cmd_y0;
      w_q      <= bus.cmd_w;
      h_q      <= bus.cmd_h;
      key_en_q <= bus.cmd_key_en;
      key_q    <= bus.cmd_key;
      col_p0   <= '0;
      row_p0   <= '0;
    end else if (vld_p0) begin
      if (col_p0 == w_q - XW'(1)) begin
        col_p0 <= '0;
        row_p0 <= row_p0 + YW'(1);
      end else begin
        col_p0 <= col_p0 + XW'(1);
      end
    end
  end

  // Stage p1: ROM read in flight; screen coordinates carry one extra bit so an
  // overflowing sum is clipped rather than wrapping back on screen.
  always_ff @(posedge clock) begin
    if (!resetn) vld_p1 <= 1'b0;
    else         vld_p1 <= vld_p0 && !kill;
  end

  always_ff @(posedge clock) begin
    x_p1 <= {1'b0, x0_q} + {1'b0, col_p0};
    y_p1 <= {1'b0, y0_q} + {1'b0, row_p0};
  end

  // Stage p2: registered pixel write; coordinates and colour hold between writes.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      vld_p2    <= 1'b0;
      x_p2      <= '0;
      y_p2      <= '0;
      colour_p2 <= '0;
    end else begin
      vld_p2 <= 1'b0;
      if (vld_p1 && !kill && !x_clipped(x_p1) && !y_clipped(y_p1) &&
          !keyed_out(key_en_q, key_q, bus.rom_data)) begin
        vld_p2    <= 1'b1;
        x_p2      <= x_p1[XW-1:0];
        y_p2      <= y_p1[YW-1:0];
        colour_p2 <= bus.rom_data;
      end
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.rom_addr  = rom_addr_p0;
  assign bus.rom_sel   = rom_sel_q;
  assign bus.write_en  = vld_p2;
  assign bus.x         = x_p2;
  assign bus.y         = y_p2;
  assign bus.colour    = colour_p2;

endmodule

// File: tb/tb_region_blitter.sv
// Randomized bench for region_blitter: a list-of-writes reference model built
// from pixel coordinates, clip rules and colour key, compared cycle by cycle.
module tb_region_blitter;
  localparam int ROM_WORDS = 131072;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  region_blitter_if #(.XW(9), .YW(8), .COLW(3), .AW(17), .SELW(4)) bus ();

  region_blitter #(.SCREEN_W(320), .SCREEN_H(240), .XW(9), .YW(8), .COLW(3),
                   .AW(17), .SELW(4)) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  logic [2:0] rom_mem [ROM_WORDS];

  always @(posedge clock) bus.rom_data <= rom_mem[bus.rom_addr] ^ bus.rom_sel[2:0];

  typedef struct {int cyc; int x; int y; int c;} wr_t;
  wr_t exp_q [$];

  int n_checks = 0;
  int n_pass   = 0;
  int last_x = 0, last_y = 0, last_c = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_reset_values();
    chk("rst_cmd_ready", int'(bus.cmd_ready), 1);
    chk("rst_busy",      int'(bus.busy), 0);
    chk("rst_done",      int'(bus.done), 0);
    chk("rst_write_en",  int'(bus.write_en), 0);
    chk("rst_x",         int'(bus.x), 0);
    chk("rst_y",         int'(bus.y), 0);
    chk("rst_colour",    int'(bus.colour), 0);
    chk("rst_rom_addr",  int'(bus.rom_addr), 0);
    chk("rst_rom_sel",   int'(bus.rom_sel), 0);
  endtask

  task automatic drive_fields(input int x0, input int y0, input int w, input int h,
                              input int base, input int sel, input int ke, input int key);
    bus.cmd_x0     = 9'(x0);
    bus.cmd_y0     = 8'(y0);
    bus.cmd_w      = 9'(w);
    bus.cmd_h      = 8'(h);
    bus.cmd_base   = 17'(base);
    bus.cmd_sel    = 4'(sel);
    bus.cmd_key_en = 1'(ke);
    bus.cmd_key    = 3'(key);
  endtask

  // Returns just after the accepting rising edge.
  task automatic start_cmd(input int x0, input int y0, input int w, input int h,
                           input int base, input int sel, input int ke, input int key);
    int t = 0;
    @(negedge clock);
    while (!bus.cmd_ready && t < 1000) begin
      @(negedge clock);
      t++;
    end
    if (!bus.cmd_ready) chk("ready_timeout", 0, 1);
    drive_fields(x0, y0, w, h, base, sel, ke, key);
    bus.cmd_valid = 1'b1;
    @(posedge clock);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input int x0, input int y0, input int w, input int h,
                         input int base, input int sel, input int ke, input int key,
                         input int abort_at);
    int n, done_cycle, busy_end;
    n          = w * h;
    done_cycle = (n == 0) ? 1 : n + 3;
    busy_end   = (abort_at >= 0) ? abort_at : done_cycle;
    exp_q.delete();
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        int cyc, addr, col, xx, yy;
        cyc = r * w + c + 3;
        if (abort_at >= 0 && cyc > abort_at) continue;
        addr = (base + r * w + c) % ROM_WORDS;
        col  = int'(rom_mem[addr]) ^ (sel & 7);
        xx   = x0 + c;
        yy   = y0 + r;
        if (xx < 320 && yy < 240 && !(ke != 0 && col == key))
          exp_q.push_back('{cyc: cyc, x: xx, y: yy, c: col});
      end

    start_cmd(x0, y0, w, h, base, sel, ke, key);
    for (int k = 1; k <= busy_end + 1; k++) begin
      logic exp_we;
      @(negedge clock);
      if (k <= n && (abort_at < 0 || k <= abort_at)) begin
        chk("rom_addr", int'(bus.rom_addr), (base + k - 1) % ROM_WORDS);
        chk("rom_sel",  int'(bus.rom_sel), sel);
      end
      exp_we = (exp_q.size() > 0) && (exp_q[0].cyc == k);
      chk("write_en", int'(bus.write_en), int'(exp_we));
      if (exp_we) begin
        chk("x", int'(bus.x), exp_q[0].x);
        chk("y", int'(bus.y), exp_q[0].y);
        chk("colour", int'(bus.colour), exp_q[0].c);
        last_x = exp_q[0].x;
        last_y = exp_q[0].y;
        last_c = exp_q[0].c;
        void'(exp_q.pop_front());
      end else begin
        chk("hold_x", int'(bus.x), last_x);
        chk("hold_y", int'(bus.y), last_y);
        chk("hold_colour", int'(bus.colour), last_c);
      end
      chk("done", int'(bus.done), int'(abort_at < 0 && k == done_cycle));
      chk("busy", int'(bus.busy), int'(k <= busy_end));
      if (k == busy_end + 1) chk("cmd_ready", int'(bus.cmd_ready), 1);
      if (abort_at >= 0 && k == abort_at) bus.abort = 1'b1;
      if (abort_at >= 0 && k == abort_at + 1) bus.abort = 1'b0;
      if (k == 2 && busy_end >= 3) begin
        drive_fields($urandom_range(0, 511), $urandom_range(0, 255), $urandom_range(1, 9),
                     $urandom_range(1, 9), $urandom, $urandom_range(0, 15), 1, 0);
        bus.cmd_valid = 1'b1;
      end
      if (k == 3) bus.cmd_valid = 1'b0;
    end
    bus.abort     = 1'b0;
    bus.cmd_valid = 1'b0;
    chk("pending_writes", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < ROM_WORDS; i++) rom_mem[i] = 3'($urandom);
    resetn        = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.abort     = 1'b0;
    drive_fields(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_values();
    resetn = 1'b1;

    run_cmd(10, 20, 2, 2, 100, 0, 0, 0, -1);
    run_cmd(318, 239, 4, 2, 5000, 3, 0, 0, -1);
    rom_mem[2000] = 3'd0;
    rom_mem[2001] = 3'd5;
    rom_mem[2002] = 3'd0;
    rom_mem[2003] = 3'd7;
    run_cmd(50, 60, 4, 1, 2000, 0, 1, 0, -1);
    run_cmd(30, 30, 0, 5, 77, 1, 0, 0, -1);
    run_cmd(505, 250, 10, 3, 131070, 5, 0, 0, -1);
    run_cmd(0, 0, 320, 240, 9000, 2, 0, 0, 50);
    run_cmd(100, 100, 3, 2, 400, 6, 0, 0, -1);
    run_cmd(40, 40, 2, 2, 700, 0, 0, 0, 5);

    for (int t = 0; t < 12; t++) begin
      int w, h, ab;
      w  = $urandom_range(0, 12);
      h  = $urandom_range(0, 6);
      ab = -1;
      if (w * h > 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(1, w * h + 2);
      run_cmd($urandom_range(0, 511), $urandom_range(0, 255), w, h,
              (t % 3 == 0) ? $urandom_range(131060, 131071) : $urandom_range(0, 131071),
              $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 7), ab);
    end

    start_cmd(5, 5, 10, 10, 300, 9, 0, 0);
    repeat (4) @(negedge clock);
    chk("pre_reset_busy", int'(bus.busy), 1);
    resetn = 1'b0;
    @(negedge clock);
    check_reset_values();
    resetn = 1'b1;
    last_x = 0;
    last_y = 0;
    last_c = 0;
    run_cmd(12, 34, 3, 3, 1234, 4, 0, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
